// File: rtl/dds_step_controller.sv
// Phase-step controller for a DDS: six active-low buttons (coarse/medium/fine, add/sub)
// are synchronised, debounced and auto-repeated into a saturating step word.
module dds_step_controller #(
    parameter int unsigned WIDTH      = 23,
    parameter int unsigned STEP_MIN   = 10000,
    parameter int unsigned STEP_MAX   = 2000000,
    parameter int unsigned STEP_INIT  = 10000,
    parameter int unsigned INC_COARSE = 10000,
    parameter int unsigned INC_MEDIUM = 1000,
    parameter int unsigned INC_FINE   = 1,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned RPT_DELAY  = 25000000,
    parameter int unsigned RPT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_add_n,
    input  logic             btn_sub_n,
    input  logic             btn_madd_n,
    input  logic             btn_msub_n,
    input  logic             btn_fadd_n,
    input  logic             btn_fsub_n,
    output logic [WIDTH-1:0] step,
    output logic             step_chg,
    output logic             at_min,
    output logic             at_max
);

    localparam int unsigned NBTN    = 6;
    localparam int unsigned DEB_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(STEP_MIN);
    localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(STEP_MAX);
    localparam logic [WIDTH:0]   INC_C    = (WIDTH+1)'(INC_COARSE);
    localparam logic [WIDTH:0]   INC_M    = (WIDTH+1)'(INC_MEDIUM);
    localparam logic [WIDTH:0]   INC_F    = (WIDTH+1)'(INC_FINE);
    localparam logic [WIDTH-1:0] MIN_S    = WIDTH'(STEP_MIN);
    localparam logic [WIDTH-1:0] MAX_S    = WIDTH'(STEP_MAX);
    localparam logic [WIDTH-1:0] INIT_S   = WIDTH'(STEP_INIT);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HOLD, S_REPEAT} state_e;

    logic [NBTN-1:0]  btn_n;
    logic [NBTN-1:0]  sync1_q, sync2_q;
    logic [NBTN-1:0]  deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q [NBTN];
    logic [DEB_W-1:0] deb_cnt_d [NBTN];
    state_e           state_q   [NBTN];
    state_e           state_d   [NBTN];
    logic [RPT_W-1:0] rpt_cnt_q [NBTN];
    logic [RPT_W-1:0] rpt_cnt_d [NBTN];
    logic [NBTN-1:0]  req;

    logic [WIDTH-1:0] step_q, step_d;
    logic             step_chg_q, step_chg_d;
    logic             at_min_q, at_min_d;
    logic             at_max_q, at_max_d;
    logic             do_add, do_sub;
    logic [WIDTH:0]   inc, wide, sum;

    // Bit order: coarse add/sub, medium add/sub, fine add/sub; pairs map to priority groups.
    assign btn_n = {btn_fsub_n, btn_fadd_n, btn_msub_n, btn_madd_n, btn_sub_n, btn_add_n};

    always_comb begin
        for (int unsigned i = 0; i < NBTN; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            req[i]       = 1'b0;

            // Counter runs only while the synced level disagrees with the accepted one,
            // so any bounce back to the accepted level restarts the window.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end

            case (state_q[i])
                S_IDLE: if (!deb_q[i]) state_d[i] = S_PRESS;
                S_PRESS: begin
                    req[i]       = 1'b1;
                    rpt_cnt_d[i] = '0;
                    state_d[i]   = deb_q[i] ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (deb_q[i]) state_d[i] = S_IDLE;
                    else if (rpt_cnt_q[i] == DELAY_LAST) begin
                        req[i]       = 1'b1;
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = S_REPEAT;
                    end else rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                end
                S_REPEAT: begin
                    if (deb_q[i]) state_d[i] = S_IDLE;
                    else if (rpt_cnt_q[i] == PERIOD_LAST) begin
                        req[i]       = 1'b1;
                        rpt_cnt_d[i] = '0;
                    end else rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        do_add = 1'b0;
        do_sub = 1'b0;
        inc    = '0;
        if (req[1:0] != 2'b00) begin
            do_add = req[0]; do_sub = req[1]; inc = INC_C;
        end else if (req[3:2] != 2'b00) begin
            do_add = req[2]; do_sub = req[3]; inc = INC_M;
        end else if (req[5:4] != 2'b00) begin
            do_add = req[4]; do_sub = req[5]; inc = INC_F;
        end

        wide   = {1'b0, step_q};
        sum    = wide + inc;
        step_d = step_q;
        if (do_add && !do_sub) step_d = (sum > MAX_W) ? MAX_S : WIDTH'(sum);
        else if (do_sub && !do_add) step_d = (wide < MIN_W + inc) ? MIN_S : WIDTH'(wide - inc);

        step_chg_d = (step_d != step_q);
        at_min_d   = (step_d == MIN_S);
        at_max_d   = (step_d == MAX_S);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            for (int unsigned i = 0; i < NBTN; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= S_IDLE;
                rpt_cnt_q[i] <= '0;
            end
            step_q     <= INIT_S;
            step_chg_q <= 1'b0;
            at_min_q   <= (INIT_S == MIN_S);
            at_max_q   <= (INIT_S == MAX_S);
        end else begin
            sync1_q    <= btn_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int unsigned i = 0; i < NBTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            step_q     <= step_d;
            step_chg_q <= step_chg_d;
            at_min_q   <= at_min_d;
            at_max_q   <= at_max_d;
        end
    end

    assign step     = step_q;
    assign step_chg = step_chg_q;
    assign at_min   = at_min_q;
    assign at_max   = at_max_q;

endmodule

// File: tb/tb_dds_step_controller.sv
// Directed plus randomised bench for dds_step_controller; a hold-duration model predicts
// how many requests each press produces and applies the clamped step rules to them.
module tb_dds_step_controller;

    localparam int unsigned WIDTH    = 23;
    localparam int          SMIN     = 10000;
    localparam int          SMAX     = 2000000;
    localparam int          SINIT    = 10000;
    localparam int          DEB      = 4;
    localparam int          RDELAY   = 20;
    localparam int          RPERIOD  = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       btn_n = '1;
    logic [WIDTH-1:0] step;
    logic             step_chg, at_min, at_max;

    int errors = 0;
    int checks = 0;
    int chg_cnt = 0;
    int exp_step = SINIT;
    int exp_chg = 0;

    dds_step_controller #(
        .WIDTH(WIDTH), .STEP_MIN(SMIN), .STEP_MAX(SMAX), .STEP_INIT(SINIT),
        .INC_COARSE(10000), .INC_MEDIUM(1000), .INC_FINE(1),
        .DEB_CYCLES(DEB), .RPT_DELAY(RDELAY), .RPT_PERIOD(RPERIOD)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_add_n(btn_n[0]), .btn_sub_n(btn_n[1]),
        .btn_madd_n(btn_n[2]), .btn_msub_n(btn_n[3]),
        .btn_fadd_n(btn_n[4]), .btn_fsub_n(btn_n[5]),
        .step(step), .step_chg(step_chg), .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) chg_cnt = 0;
        else if (step_chg) chg_cnt = chg_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Requests produced by a press whose raw level was low for h sampled edges.
    function automatic int n_requests(input int h);
        if (h < DEB) return 0;
        if (h - 2 < RDELAY) return 1;
        return 2 + (h - 2 - RDELAY) / RPERIOD;
    endfunction

    function automatic int next_step(input int s, input logic [5:0] m);
        int inc;
        logic a, b;
        if (m[1:0] != 2'b00) begin a = m[0]; b = m[1]; inc = 10000; end
        else if (m[3:2] != 2'b00) begin a = m[2]; b = m[3]; inc = 1000; end
        else if (m[5:4] != 2'b00) begin a = m[4]; b = m[5]; inc = 1; end
        else return s;
        if (a && !b) return (s + inc > SMAX) ? SMAX : s + inc;
        if (b && !a) return (s - inc < SMIN) ? SMIN : s - inc;
        return s;
    endfunction

    task automatic model_hold(input logic [5:0] m, input int h);
        int ns;
        for (int k = 0; k < n_requests(h); k++) begin
            ns = next_step(exp_step, m);
            if (ns != exp_step) exp_chg++;
            exp_step = ns;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_step"}, int'(step), exp_step);
        check({tag, "_at_min"}, int'(at_min), int'(exp_step == SMIN));
        check({tag, "_at_max"}, int'(at_max), int'(exp_step == SMAX));
        check({tag, "_chg_count"}, chg_cnt, exp_chg);
    endtask

    task automatic press(input logic [5:0] m, input int h, input string tag);
        btn_n = ~m;
        tick(h);
        btn_n = '1;
        tick(DEB + 12);
        model_hold(m, h);
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_step = SINIT;
        exp_chg = 0;
        tick(2);
    endtask

    initial begin
        logic [5:0] m;
        int h;

        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_step", int'(step), 10000);
        check("rst_at_min", int'(at_min), 1);
        check("rst_at_max", int'(at_max), 0);
        check("rst_chg", int'(step_chg), 0);

        // First-press latency: step moves on the (DEB+4)th edge after the input falls.
        btn_n[0] = 1'b0;
        tick(DEB + 3);
        check("lat_before", int'(step), 10000);
        tick(1);
        check("lat_step", int'(step), 20000);
        check("lat_chg", int'(step_chg), 1);
        tick(10 - (DEB + 4));
        btn_n = '1;
        tick(DEB + 12);
        model_hold(6'b000001, 10);
        check_state("coarse10");
        check("coarse10_const", int'(step), 20000);

        press(6'b000001, 3, "glitch");
        press(6'b000010, 10, "coarse_sub");

        press(6'b000100, 50, "medium_hold50");
        check("medium_hold50_const", int'(step), 17000);

        do_reset();
        press(6'b000001, 1002, "climb_coarse");
        press(6'b000100, 37, "climb_medium");
        check("climb_const", int'(step), 1995000);
        press(6'b000001, 10, "sat_hit");
        check("sat_hit_max", int'(at_max), 1);
        press(6'b000001, 10, "sat_noop");
        check("sat_noop_step", int'(step), 2000000);

        do_reset();
        press(6'b010000, 2512, "fine_climb");
        check("fine_climb_const", int'(step), 10500);
        press(6'b001000, 10, "min_clamp");
        check("min_clamp_const", int'(step), 10000);

        press(6'b010001, 10, "coarse_over_fine");
        check("coarse_over_fine_const", int'(step), 20000);
        press(6'b110000, 10, "fine_cancel");
        check("fine_cancel_const", int'(step), 20000);

        for (int r = 0; r < 24; r++) begin
            m = 6'b000001 << $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) m = m | (6'b000001 << $urandom_range(0, 5));
            h = $urandom_range(1, 60);
            press(m, h, $sformatf("rand%0d", r));
        end

        // Reset while in auto-repeat: immediate return to init, nothing left pending.
        btn_n[2] = 1'b0;
        tick(40);
        reset = 1'b1;
        #1;
        check("mid_rpt_step", int'(step), SINIT);
        check("mid_rpt_at_min", int'(at_min), 1);
        check("mid_rpt_chg", int'(step_chg), 0);
        btn_n = '1;
        tick(3);
        reset = 1'b0;
        exp_step = SINIT;
        exp_chg = 0;
        tick(30);
        check_state("post_rpt_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
